ham21_encoder_stream: RTL and testbench

//  Streaming Hamming(21,16) even-parity SEC encoder: the transmit end of the
//  21-bit codeword link whose decoder checks and corrects on receive.
//  - Accepts 16-bit data words on a valid/ready input.
//  - Emits 21-bit codewords on a valid/ready output, one word per cycle.
//  - One-shot single-bit error injection, so decoder correction can be exercised end to end.

---
 rtl/ham21_encoder_stream.sv | 111 +++++++++++
 tb/tb_ham21_encoder_stream.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ham21_encoder_stream.sv
// Streaming Hamming(21,16) even-parity encoder with a 1-entry skid buffer and
// one-shot single-bit error injection for exercising the decoder end to end.
module ham21_encoder_stream #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [20:0]      out_code,
    input  logic             inj_arm,
    input  logic [4:0]       inj_pos,
    output logic             inj_armed,
    output logic [CNT_W-1:0] word_cnt
);

    // Bit i of the codeword is Hamming position i+1; masks select positions with bit k set.
    function automatic logic [20:0] f_encode(input logic [15:0] d);
        logic [20:0] c;
        c        = '0;
        c[2]     = d[0];
        c[6:4]   = d[3:1];
        c[14:8]  = d[10:4];
        c[20:16] = d[15:11];
        c[0]     = ^(c & 21'h155555);
        c[1]     = ^(c & 21'h066666);
        c[3]     = ^(c & 21'h187878);
        c[7]     = ^(c & 21'h007F80);
        c[15]    = ^(c & 21'h1F8000);
        return c;
    endfunction

    logic             r_live;
    logic             r_out_valid;
    logic [20:0]      r_out_code;
    logic             r_skid_valid;
    logic [20:0]      r_skid_code;
    logic             r_inj_armed;
    logic [4:0]       r_inj_pos;
    logic [CNT_W-1:0] r_word_cnt;

    logic             w_acc;
    logic             w_ho;
    logic [20:0]      w_flip;
    logic [20:0]      w_enc;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready  = r_live & ~r_skid_valid;
    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign inj_armed = r_inj_armed;
    assign word_cnt  = r_word_cnt;

    assign w_acc = in_valid & in_ready;
    assign w_ho  = r_out_valid & out_ready;

    always_comb begin
        w_flip = '0;
        if (r_inj_armed && r_inj_pos >= 5'd1 && r_inj_pos <= 5'd21)
            w_flip = 21'd1 << (r_inj_pos - 5'd1);
    end

    assign w_enc = f_encode(in_data) ^ w_flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_code   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_code  <= '0;
            r_inj_armed  <= 1'b0;
            r_inj_pos    <= '0;
            r_word_cnt   <= '0;
        end else begin
            r_live <= 1'b1;

            if (w_ho) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
                if (r_skid_valid) begin
                    r_out_code   <= r_skid_code;
                    r_skid_valid <= 1'b0;
                end else if (w_acc) begin
                    r_out_code <= w_enc;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_acc) begin
                if (r_out_valid) begin
                    r_skid_code  <= w_enc;
                    r_skid_valid <= 1'b1;
                end else begin
                    r_out_code  <= w_enc;
                    r_out_valid <= 1'b1;
                end
            end

            // A same-cycle arm targets the word after the one accepted now.
            if (inj_arm) begin
                r_inj_armed <= 1'b1;
                r_inj_pos   <= inj_pos;
            end else if (w_acc) begin
                r_inj_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ham21_encoder_stream.sv
// Scoreboard bench: driver pushes reference codewords, monitor pops on each handoff.
module tb_ham21_encoder_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [20:0] out_code;
    logic        inj_arm = 1'b0;
    logic [4:0]  inj_pos = '0;
    logic        inj_armed;
    logic [15:0] word_cnt;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [20:0] exp_q[$];
    int          m_cnt = 0;
    bit          m_armed = 1'b0;
    logic [4:0]  m_pos = '0;
    bit          bp_run = 1'b0;

    ham21_encoder_stream #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_armed(inj_armed),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Reference: walk positions 1..21, place data at non-powers of two, then
    // each parity bit 2^k is the XOR of every set position whose index has bit k.
    function automatic logic [20:0] m_encode(input logic [15:0] d);
        logic [20:0] c;
        int          j;
        int          par;
        c = '0;
        j = 0;
        for (int p = 1; p <= 21; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (((d >> j) & 16'd1) != 16'd0) c = c | (21'd1 << (p - 1));
                j++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            par = 0;
            for (int p = 1; p <= 21; p++)
                if (((p >> k) & 1) == 1 && ((c >> (p - 1)) & 21'd1) != 21'd0) par = par ^ 1;
            if (par == 1) c = c | (21'd1 << ((1 << k) - 1));
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, req);
    endtask

    // Monitor: every handoff pops one expected codeword and checks the counter.
    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected word: got %0h want none", out_code);
                end else begin
                    e = exp_q.pop_front();
                    check("out_code", 32'(out_code), 32'(e));
                end
                check("word_cnt", 32'(word_cnt), 32'(m_cnt & 'hFFFF));
                m_cnt++;
            end
        end
    end

    task automatic send(input logic [15:0] d, input bit use_k, input logic [20:0] k, input bit chk_b2b);
        int          w;
        logic [20:0] e;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_chk++;
            $display("FAIL accept timeout: got in_ready=0 want 1 for data %0h", d);
            in_valid = 1'b0;
            return;
        end
        e = m_encode(d);
        if (m_armed && m_pos >= 5'd1 && m_pos <= 5'd21) e = e ^ (21'd1 << (m_pos - 5'd1));
        if (use_k) e = k;
        m_armed = 1'b0;
        exp_q.push_back(e);
        if (chk_b2b) check("in_ready b2b stall", 32'(w), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("inj_armed", 32'(inj_armed), 32'(m_armed));
    endtask

    task automatic arm(input logic [4:0] p);
        @(posedge clk);
        #1;
        inj_arm = 1'b1;
        inj_pos = p;
        @(posedge clk);
        #1;
        inj_arm = 1'b0;
        m_armed = 1'b1;
        m_pos   = p;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        check("drain pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        #5000000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // 1: reset values, then single word latency
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst inj_armed", 32'(inj_armed), 32'd0);
        check("rst word_cnt", 32'(word_cnt), 32'd0);
        check("rst out_code", 32'(out_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after release", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send(16'h000A, 1'b1, 21'h000052, 1'b0);
        check("latency out_valid", 32'(out_valid), 32'd1);
        check("latency out_code", 32'(out_code), 32'h52);
        drain();
        check("word_cnt after one", 32'(word_cnt), 32'd1);

        // 2: back-to-back
        send(16'h4A40, 1'b1, 21'h092400, 1'b0);
        send(16'h000A, 1'b1, 21'h000052, 1'b1);
        send(16'hFFFF, 1'b0, 21'h0,      1'b1);
        send(16'h0000, 1'b1, 21'h000000, 1'b1);
        drain();

        // 3: backpressure fills output register and skid
        out_ready = 1'b0;
        send(16'h1234, 1'b0, 21'h0, 1'b0);
        send(16'h5678, 1'b0, 21'h0, 1'b0);
        check("full in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 16'h9ABC;
        repeat (3) @(posedge clk);
        #1;
        check("full held in_ready", 32'(in_ready), 32'd0);
        check("full out_code stable", 32'(out_code), 32'(m_encode(16'h1234)));
        out_ready = 1'b1;
        send(16'h9ABC, 1'b0, 21'h0, 1'b0);
        drain();

        // 4: injection
        arm(5'd8);
        check("armed after arm", 32'(inj_armed), 32'd1);
        send(16'h4A40, 1'b1, 21'h092480, 1'b0);
        send(16'h4A40, 1'b1, 21'h092400, 1'b0);
        arm(5'd20);
        send(16'h4A40, 1'b1, 21'h012400, 1'b0);
        send(16'h4A40, 1'b1, 21'h092400, 1'b0);
        arm(5'd3);
        arm(5'd21);
        send(16'hFFFF, 1'b0, 21'h0, 1'b0);
        drain();

        // 5: out-of-range injection, then counter wrap
        arm(5'd0);
        send(16'h000A, 1'b1, 21'h000052, 1'b0);
        arm(5'd27);
        send(16'hBEEF, 1'b0, 21'h0, 1'b0);
        drain();

        // random data and injection under random backpressure
        bp_run = 1'b1;
        fork
            while (bp_run) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) arm(5'($urandom_range(0, 31)));
            send(16'($urandom), 1'b0, 21'h0, 1'b0);
        end
        bp_run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        n = 16'hFFFF - (m_cnt & 'hFFFF);
        for (int i = 0; i < n; i++) send(16'($urandom), 1'b0, 21'h0, 1'b0);
        drain();
        check("word_cnt at max", 32'(word_cnt), 32'hFFFF);
        send(16'h000A, 1'b1, 21'h000052, 1'b0);
        drain();
        check("word_cnt wrap", 32'(word_cnt), 32'd0);

        // 6: reset with skid full and injection armed
        out_ready = 1'b0;
        send(16'h1111, 1'b0, 21'h0, 1'b0);
        send(16'h2222, 1'b0, 21'h0, 1'b0);
        arm(5'd5);
        check("armed before reset", 32'(inj_armed), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst in_ready", 32'(in_ready), 32'd0);
        check("mid rst inj_armed", 32'(inj_armed), 32'd0);
        check("mid rst word_cnt", 32'(word_cnt), 32'd0);
        check("mid rst out_code", 32'(out_code), 32'd0);
        exp_q.delete();
        m_cnt   = 0;
        m_armed = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h000A, 1'b1, 21'h000052, 1'b0);
        drain();
        check("word_cnt post reset", 32'(word_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
